// File: rtl/scroll_sequencer.sv
// -----------------------------------------------------------------------------
// scroll_sequencer
//
// Moves text lines inside the active scroll region of the character buffer and
// arbitrates the buffer's single RAM port between the character writer and the
// scroll engine.
//
// A scroll request is latched in IDLE. The region is then checked, and the
// engine walks the destination rows one cell at a time:
//   - copy rows:  READ the source cell, then WRITE it to the destination cell
//                 using the RAM read data of the previous cycle;
//   - fill rows:  write the blank cell, one cell per cycle.
// Up scrolls visit rows top -> bottom, down scrolls bottom -> top. With that
// order every source cell is read before it is overwritten.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   scroll_req/dir/n/top/bottom/blank
//                            scroll command (sampled only while idle)
//   scroll_busy, scroll_done registered status (busy SETUP..DONE, done pulse)
//   wr_req/wr_addr/wr_data   character writer access
//   wr_grant                 writer owns the RAM port this cycle
//   ram_addr/we/wdata/rdata  single RAM port (read data one cycle late)
// -----------------------------------------------------------------------------
module scroll_sequencer #(
  parameter int COLUMNS = 80,
  parameter int LINES   = 25,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scroll_req,
  input  logic              scroll_dir,
  input  logic [7:0]        scroll_n,
  input  logic [7:0]        scroll_top,
  input  logic [7:0]        scroll_bottom,
  input  logic [DATA_W-1:0] blank,
  output logic              scroll_busy,
  output logic              scroll_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int                COL_W    = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLUMNS - 1);
  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(COLUMNS);
  localparam logic [8:0]        LINES_9  = 9'(LINES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_FILL  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // row * COLUMNS built from shifted copies of the row for each set bit of
  // COLUMNS, so the constant multiply becomes a small adder tree.
  function automatic logic [ADDR_W-1:0] row_base(input logic [8:0] row);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      if (((COLUMNS >> b) & 1) != 0) begin
        acc = acc + (ADDR_W'(row) << b);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  state_e              state_q, state_d;
  logic                dir_q, dir_d;
  logic [7:0]          n_q, n_d;
  logic [7:0]          top_q, top_d;
  logic [7:0]          bot_q, bot_d;
  logic [DATA_W-1:0]   blank_q, blank_d;
  logic [ADDR_W-1:0]   src_q, src_d;     // source row base (row*COLUMNS)
  logic [ADDR_W-1:0]   dst_q, dst_d;     // destination row base
  logic [COL_W-1:0]    col_q, col_d;
  logic [8:0]          copy_q, copy_d;   // copy rows still to do
  logic [8:0]          fill_q, fill_d;   // fill rows still to do
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [8:0]          height_s;
  logic                invalid_s;
  logic [8:0]          n_eff_s;
  logic [8:0]          copy_rows_s;
  logic [8:0]          dst_row_s;
  logic [8:0]          src_row_s;
  logic [ADDR_W-1:0]   dst_step_s;
  logic [ADDR_W-1:0]   src_step_s;

  // Region geometry and row-base stepping derived from the latched command.
  always_comb begin
    height_s  = {1'b0, bot_q} - {1'b0, top_q} + 9'd1;
    invalid_s = (top_q > bot_q) || ({1'b0, bot_q} >= LINES_9);
    if (n_q == 8'd0) begin
      n_eff_s = 9'd1;
    end else if ({1'b0, n_q} > height_s) begin
      n_eff_s = height_s;
    end else begin
      n_eff_s = {1'b0, n_q};
    end
    copy_rows_s = height_s - n_eff_s;
    // Source row is only meaningful when there are copy rows.
    if (dir_q) begin
      dst_row_s = {1'b0, bot_q};
      src_row_s = {1'b0, bot_q} - n_eff_s;
      dst_step_s = dst_q - COL_STEP;
      src_step_s = src_q - COL_STEP;
    end else begin
      dst_row_s = {1'b0, top_q};
      src_row_s = {1'b0, top_q} + n_eff_s;
      dst_step_s = dst_q + COL_STEP;
      src_step_s = src_q + COL_STEP;
    end
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    n_d     = n_q;
    top_d   = top_q;
    bot_d   = bot_q;
    blank_d = blank_q;
    src_d   = src_q;
    dst_d   = dst_q;
    col_d   = col_q;
    copy_d  = copy_q;
    fill_d  = fill_q;
    case (state_q)
      S_IDLE: begin
        if (scroll_req) begin
          dir_d   = scroll_dir;
          n_d     = scroll_n;
          top_d   = scroll_top;
          bot_d   = scroll_bottom;
          blank_d = blank;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (invalid_s) begin
          state_d = S_DONE;
        end else begin
          dst_d   = row_base(dst_row_s);
          src_d   = row_base(src_row_s);
          col_d   = '0;
          copy_d  = copy_rows_s;
          fill_d  = n_eff_s;
          state_d = (copy_rows_s != 9'd0) ? S_READ : S_FILL;
        end
      end
      S_READ: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (col_q == COL_LAST) begin
          col_d   = '0;
          dst_d   = dst_step_s;
          src_d   = src_step_s;
          copy_d  = copy_q - 9'd1;
          // At least one fill row always follows the copy rows.
          state_d = (copy_q == 9'd1) ? S_FILL : S_READ;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = S_READ;
        end
      end
      S_FILL: begin
        if (col_q == COL_LAST) begin
          col_d   = '0;
          dst_d   = dst_step_s;
          fill_d  = fill_q - 9'd1;
          state_d = (fill_q == 9'd1) ? S_DONE : S_FILL;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = S_FILL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, command and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      n_q     <= 8'd0;
      top_q   <= 8'd0;
      bot_q   <= 8'd0;
      blank_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      col_q   <= '0;
      copy_q  <= 9'd0;
      fill_q  <= 9'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      n_q     <= n_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      blank_q <= blank_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      col_q   <= col_d;
      copy_q  <= copy_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // RAM port steering and grant; the writer passes straight through when idle.
  always_comb begin
    wr_grant  = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (state_q)
      S_IDLE: begin
        wr_grant  = 1'b1;
        ram_addr  = wr_addr;
        ram_we    = wr_req;
        ram_wdata = wr_data;
      end
      S_READ: begin
        ram_addr = src_q + ADDR_W'(col_q);
      end
      S_WRITE: begin
        ram_addr  = dst_q + ADDR_W'(col_q);
        ram_we    = 1'b1;
        ram_wdata = ram_rdata;
      end
      S_FILL: begin
        ram_addr  = dst_q + ADDR_W'(col_q);
        ram_we    = 1'b1;
        ram_wdata = blank_q;
      end
      default: begin
        ram_addr = '0;
      end
    endcase
  end

  assign scroll_busy = busy_q;
  assign scroll_done = done_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Bench for scroll_sequencer: a synchronous RAM, a cycle-count model of the
// busy window, and a row-shuffle model of the expected buffer contents.
module tb_scroll_sequencer;

  localparam int COLS = 80;
  localparam int LNS  = 25;
  localparam int AW   = 12;
  localparam int DW   = 16;
  localparam int MEMN = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          scroll_req = 1'b0;
  logic          scroll_dir = 1'b0;
  logic [7:0]    scroll_n = 8'd0;
  logic [7:0]    scroll_top = 8'd0;
  logic [7:0]    scroll_bottom = 8'd0;
  logic [DW-1:0] blank = 16'h0000;
  logic          scroll_busy;
  logic          scroll_done;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = 12'd0;
  logic [DW-1:0] wr_data = 16'h0000;
  logic          wr_grant;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  scroll_sequencer #(.COLUMNS(COLS), .LINES(LNS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .scroll_req(scroll_req), .scroll_dir(scroll_dir), .scroll_n(scroll_n),
    .scroll_top(scroll_top), .scroll_bottom(scroll_bottom), .blank(blank),
    .scroll_busy(scroll_busy), .scroll_done(scroll_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wr_grant),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial forever #5 clk = ~clk;

  // ---------------- RAM ----------------
  logic [DW-1:0] mem [0:MEMN-1];
  logic [DW-1:0] rdata_q;
  logic          do_prefill = 1'b0;

  always @(posedge clk) begin
    if (do_prefill) begin
      for (int i = 0; i < MEMN; i++) mem[i] <= DW'((i / COLS) * 256 + (i % COLS));
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    rdata_q <= mem[ram_addr];
  end
  assign ram_rdata = rdata_q;

  // ---------------- model ----------------
  function automatic bit region_ok(input int top, input int bot);
    return (top <= bot) && (bot < LNS);
  endfunction

  function automatic int eff_n(input int n, input int h);
    if (n == 0) return 1;
    if (n > h) return h;
    return n;
  endfunction

  function automatic int op_len(input int n, input int top, input int bot);
    int h, ne;
    if (!region_ok(top, bot)) return 2;
    h  = bot - top + 1;
    ne = eff_n(n, h);
    return 2 + 2 * (h - ne) * COLS + ne * COLS;
  endfunction

  // Busy cycles without a RAM write: SETUP, DONE and one READ per copied cell.
  function automatic int nowrite_len(input int n, input int top, input int bot);
    int h;
    if (!region_ok(top, bot)) return 2;
    h = bot - top + 1;
    return 2 + (h - eff_n(n, h)) * COLS;
  endfunction

  int rem = 0;
  bit m_valid = 1'b0;
  int m_top = 0;
  int m_bot = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem <= 0;
    end else if (rem > 0) begin
      rem <= rem - 1;
    end else if (scroll_req) begin
      rem     <= op_len(int'(scroll_n), int'(scroll_top), int'(scroll_bottom));
      m_valid <= region_ok(int'(scroll_top), int'(scroll_bottom));
      m_top   <= int'(scroll_top);
      m_bot   <= int'(scroll_bottom);
    end
  end

  logic [DW-1:0] snap [0:MEMN-1];
  logic [DW-1:0] expm [0:MEMN-1];

  task automatic build_expected(input int dir, input int n, input int top, input int bot,
                                input logic [DW-1:0] bl);
    int h, ne, s;
    for (int i = 0; i < MEMN; i++) expm[i] = snap[i];
    if (region_ok(top, bot)) begin
      h  = bot - top + 1;
      ne = eff_n(n, h);
      for (int d = top; d <= bot; d++) begin
        s = (dir != 0) ? d - ne : d + ne;
        for (int c = 0; c < COLS; c++)
          expm[d * COLS + c] = (s >= top && s <= bot) ? snap[s * COLS + c] : bl;
      end
    end
  endtask

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("busy",  32'(scroll_busy), 32'(rem > 0));
    chk("done",  32'(scroll_done), 32'(rem == 1));
    chk("grant", 32'(wr_grant),    32'(rem == 0));
    if (rem == 0) begin
      chk("mirror_addr",  32'(ram_addr),  32'(wr_addr));
      chk("mirror_we",    32'(ram_we),    32'(wr_req));
      chk("mirror_wdata", 32'(ram_wdata), 32'(wr_data));
    end else if (ram_we) begin
      chk("write_in_region",
          32'(m_valid && (int'(ram_addr) / COLS) >= m_top && (int'(ram_addr) / COLS) <= m_bot),
          32'd1);
    end
  end

  task automatic prefill();
    @(posedge clk); #1 do_prefill = 1'b1;
    @(posedge clk); #1 do_prefill = 1'b0;
  endtask

  task automatic do_scroll(input int dir, input int n, input int top, input int bot,
                           input logic [DW-1:0] bl, input int lit_len, input string nm,
                           input bit wr_hold, input bit poke);
    int cnt, nowr, dcnt, didx, mism, first_bad, len;
    cnt = 0; nowr = 0; dcnt = 0; didx = 0; mism = 0; first_bad = -1;
    @(posedge clk); #1;
    scroll_req = 1'b1; scroll_dir = dir[0]; scroll_n = 8'(n);
    scroll_top = 8'(top); scroll_bottom = 8'(bot); blank = bl;
    @(posedge clk); #1;
    scroll_req = 1'b0;
    for (int k = 1; k <= 6000; k++) begin
      @(negedge clk);
      if (k == 1) begin
        for (int i = 0; i < MEMN; i++) snap[i] = mem[i];
        if (wr_hold) begin
          wr_req = 1'b1; wr_addr = 12'd1990; wr_data = 16'hBEEF;
        end
      end
      if (poke && k == 5) begin
        scroll_req = 1'b1; scroll_n = 8'd3; scroll_top = 8'd0; scroll_bottom = 8'd24;
      end
      if (poke && k == 15) scroll_req = 1'b0;
      if (!scroll_busy) break;
      cnt++;
      if (!ram_we) nowr++;
      if (scroll_done) begin dcnt++; didx = k; end
      if (wr_hold && scroll_done) chk({nm, "_wr_waits"}, 32'(mem[1990] == 16'hBEEF), 32'd0);
    end
    len = op_len(n, top, bot);
    build_expected(dir, n, top, bot, bl);
    chk({nm, "_busy_len"}, 32'(cnt), 32'(len));
    if (lit_len >= 0) chk({nm, "_busy_lit"}, 32'(cnt), 32'(lit_len));
    chk({nm, "_done_count"}, 32'(dcnt), 32'd1);
    chk({nm, "_done_cycle"}, 32'(didx), 32'(len));
    chk({nm, "_nowrite_cycles"}, 32'(nowr), 32'(nowrite_len(n, top, bot)));
    for (int i = 0; i < MEMN; i++) begin
      if (mem[i] !== expm[i]) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (mism != 0) $display("  first bad cell %0d: %0h vs %0h", first_bad, mem[first_bad], expm[first_bad]);
    chk({nm, "_mem_mismatches"}, 32'(mism), 32'd0);
    if (wr_hold) begin
      @(posedge clk); #1;
      chk({nm, "_wr_lands"}, 32'(mem[1990]), 32'h0000BEEF);
      wr_req = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and passthrough.
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    wr_req = 1'b1; wr_addr = 12'd5; wr_data = 16'h0741;
    @(negedge clk);
    chk("pt_we",    32'(ram_we),      32'd1);
    chk("pt_addr",  32'(ram_addr),    32'd5);
    chk("pt_wdata", 32'(ram_wdata),   32'h0741);
    chk("pt_busy",  32'(scroll_busy), 32'd0);
    chk("pt_grant", 32'(wr_grant),    32'd1);
    @(posedge clk); #1 wr_req = 1'b0;

    // Full-screen scroll up.
    prefill();
    do_scroll(0, 1, 0, 24, 16'h0720, 3922, "up_full", 1'b0, 1'b0);
    chk("up_row0",   32'(mem[0]),            32'h0100);
    chk("up_row23",  32'(mem[23 * 80 + 79]), 32'h184F);
    chk("up_row24",  32'(mem[24 * 80 + 5]),  32'h0720);

    // Partial scroll down.
    prefill();
    do_scroll(1, 2, 5, 10, 16'h0720, 802, "down_part", 1'b0, 1'b0);
    chk("dn_row7",  32'(mem[7 * 80]),      32'h0500);
    chk("dn_row10", 32'(mem[10 * 80 + 3]), 32'h0803);
    chk("dn_row5",  32'(mem[5 * 80]),      32'h0720);
    chk("dn_row4",  32'(mem[4 * 80 + 1]),  32'h0401);
    chk("dn_row11", 32'(mem[11 * 80]),     32'h0B00);

    // Clamping.
    prefill();
    do_scroll(0, 0, 0, 1, 16'h0720, 242, "n_zero", 1'b0, 1'b0);
    chk("nz_row0", 32'(mem[0]),  32'h0100);
    chk("nz_row1", 32'(mem[80]), 32'h0720);
    prefill();
    do_scroll(0, 30, 0, 24, 16'h0720, 2002, "n_big", 1'b0, 1'b0);
    chk("nb_last", 32'(mem[1999]), 32'h0720);

    // Invalid regions.
    do_scroll(0, 1, 10, 5, 16'h1111, 2, "inv_order", 1'b0, 1'b0);
    do_scroll(1, 1, 0, 25, 16'h1111, 2, "inv_bottom", 1'b0, 1'b0);

    // Writer contention plus an ignored second request.
    prefill();
    do_scroll(0, 1, 2, 8, 16'h1234, 1042, "contend", 1'b1, 1'b1);

    // Reset in the middle of a copy.
    @(posedge clk); #1;
    scroll_req = 1'b1; scroll_dir = 1'b0; scroll_n = 8'd1; scroll_top = 8'd0; scroll_bottom = 8'd24;
    @(posedge clk); #1 scroll_req = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_busy_drop", 32'(scroll_busy), 32'd0);
    chk("rst_done_drop", 32'(scroll_done), 32'd0);
    chk("rst_grant",     32'(wr_grant),    32'd1);
    @(posedge clk); #1 rst = 1'b1;

    // Randomized scrolls with writer traffic in between.
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 6; w++) begin
        @(posedge clk); #1;
        wr_req  = 1'($urandom_range(0, 1));
        wr_addr = 12'($urandom_range(0, MEMN - 1));
        wr_data = 16'($urandom);
      end
      @(posedge clk); #1 wr_req = 1'b0;
      do_scroll(int'($urandom_range(0, 1)), int'($urandom_range(0, 30)),
                int'($urandom_range(0, 26)), int'($urandom_range(0, 26)),
                16'($urandom), -1, "rand", 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scroll_sequencer.md
# scroll_sequencer

Sequences scroll-region line moves in the text buffer for the VT100 parser and arbitrates the buffer's single RAM port between the character writer and the scroll engine. On a scroll request it copies rows inside the active region `[scroll_top, scroll_bottom]` (the margins set by DECSTBM) and blank-fills the vacated rows. It sits between the parser/mode logic and the text RAM, next to the character writer.

## Interface
- `COLUMNS`, 80: characters per line.
- `LINES`, 25: lines per screen.
- `ADDR_W`, 12: RAM address width; must satisfy COLUMNS*LINES ≤ 2^ADDR_W.
- `DATA_W`, 16: cell width (char + attribute).

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `scroll_req`  in  1  start pulse; sampled only in IDLE.
- `scroll_dir`  in  1  0 = up (content moves toward top), 1 = down.
- `scroll_n`  in  8  lines to scroll.
- `scroll_top`  in  8  region top row, 0-based.
- `scroll_bottom`  in  8  region bottom row, 0-based.
- `blank`  in  DATA_W  fill cell value.
- `scroll_busy`  out  1  operation in progress.
- `scroll_done`  out  1  one-cycle completion pulse.
- `wr_req`  in  1  writer access request.
- `wr_addr`  in  ADDR_W  writer address.
- `wr_data`  in  DATA_W  writer data.
- `wr_grant`  out  1  writer owns the port this cycle.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data; valid 1 cycle after the address is presented.

## Operation
- States: IDLE, SETUP, READ, WRITE, FILL, DONE.
- **IDLE**
  - `wr_grant` = 1.
  - The RAM port mirrors the writer combinationally: `ram_addr`=`wr_addr`, `ram_wdata`=`wr_data`, `ram_we`=`wr_req`.
  - `scroll_req`=1 latches dir/n/top/bottom/blank and moves to SETUP. A writer access in the same cycle still completes.
- **SETUP** (no RAM access)
  - Region height H = bottom−top+1.
  - Invalid region (top > bottom, or bottom ≥ LINES): go to DONE; no RAM writes.
  - Effective n: 0 is treated as 1; values above H are clamped to H. Copy rows C = H−n.
  - Scroll up: destination row starts at top; source row = dst+n; rows visited ascending.
  - Scroll down: destination row starts at bottom; source row = dst−n; rows visited descending.
  - Row bases are held as `row*COLUMNS`, stepped by ±COLUMNS. No multiplier.
  - Column counter starts at 0.
- **Per destination row:** columns ascend 0..COLUMNS−1.
  - First C rows (copy): READ drives `ram_addr`=src+col with `ram_we`=0. The next WRITE cycle drives `ram_addr`=dst+col, `ram_we`=1, `ram_wdata`=`ram_rdata`.
  - Remaining n rows (fill): FILL drives `ram_addr`=dst+col, `ram_we`=1, `ram_wdata`=`blank`, one cell per cycle.
- After the last cell: go to DONE. DONE asserts `scroll_done`, then returns to IDLE.
- **Outside IDLE**
  - `wr_grant`=0; the writer holds `wr_req` and waits.
  - `scroll_req` is ignored; no queuing.
- Rows outside `[top, bottom]` are never written.

## Timing
- Reset values: state IDLE, `scroll_busy`=0, `scroll_done`=0, `wr_grant`=1. RAM port mirrors the writer inputs.
- `scroll_busy` is registered: high from SETUP through DONE inclusive, low in IDLE.
- Accept cycle T (IDLE with `scroll_req`), SETUP at T+1, first cell op at T+2.
- Busy length: 2 + 2·C·COLUMNS + n·COLUMNS cycles; invalid region: 2 cycles.
- `scroll_done` is high exactly one cycle, coincident with the last busy cycle.
- `wr_grant` rises the cycle after DONE.
- Reset asserted mid-operation: immediate return to IDLE; busy/done cleared. The partially scrolled buffer contents are left as-is.

## Test plan
- **Reset/passthrough:** hold `rst`=0, then release; drive `wr_req`=1, `wr_addr`=5, `wr_data`=16'h0741 → `ram_we`=1, `ram_addr`=5, `ram_wdata`=16'h0741 the same cycle; `scroll_busy`=0, `wr_grant`=1.
- **Full-screen scroll up:** prefill cell(r,c)=r·256+c; scroll up n=1, top=0, bottom=24, blank=16'h0720.
  - Required: row r holds old row r+1 for r<24; row 24 all 16'h0720.
  - Busy lasts 3922 cycles; exactly one `scroll_done` pulse.
- **Partial scroll down:** scroll down n=2, top=5, bottom=10 on the same pattern.
  - Required: rows 7..10 hold old rows 5..8; rows 5 and 6 are blank; rows 0–4 and 11–24 are unchanged.
  - Busy lasts 2+2·4·80+2·80 = 802 cycles.
- **Clamping:**
  - n=0, top=0, bottom=1, up → identical to n=1.
  - n=30, top=0, bottom=24 → all 2000 cells blank; busy lasts 2002 cycles; no READ cycles.
- **Invalid region:** top=10, bottom=5 → busy for 2 cycles, `scroll_done` pulses at T+2, `ram_we` never asserted.
- **Contention and reset:**
  - Hold `wr_req` high across a scroll → `wr_grant`=0 throughout busy; the write lands the cycle after DONE.
  - A second `scroll_req` while busy is ignored.
  - Asserting `rst` mid-copy drops `scroll_busy` immediately.
